// File: rtl/sel_pipe_mux_pkg.sv
// Shared types for the selectable pipelined mux: buffer state encoding and
// the select-width helper used by the interface, the mux and the top.
package sel_pipe_pkg;

    // Occupancy of the two-entry (main, skid) output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Width of a source index: max(1, ceil(log2(n))).
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sel_pipe_mux_if.sv
// Handshake bundle for sel_pipe_mux.
// valid/ready rule: a transfer happens on a rising edge where valid and
// ready are both high; once valid is raised the payload holds until that
// transfer. in_valid/in_ready guard the input side (and flush blocks the
// input transfer), out_valid/out_ready guard the output side.
interface sel_pipe_mux_if
    import sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = sel_w(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    out_ready;
    logic                    flush;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;

    // Upstream/downstream environment side.
    modport master (
        output in_data, sel, in_valid, out_ready, flush,
        input  in_ready, out_valid, out_data, out_sel, out_err
    );

    // Block side.
    modport slave (
        input  in_data, sel, in_valid, out_ready, flush,
        output in_ready, out_valid, out_data, out_sel, out_err
    );

endinterface

// File: rtl/sel_pipe_mux_mux_nway.sv
// Combinational N-way source selector. An index past the last source
// yields all-zero data and raises err so the fault travels with the entry.
module mux_nway
    import sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0]    in_data_i,
    input  logic [sel_w(NUM_IN)-1:0]   sel_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       err_o
);
    localparam int SEL_W = sel_w(NUM_IN);

    // Pick the addressed source; unmatched (out-of-range) indices leave zero.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = in_data_i[k*WIDTH +: WIDTH];
            end
        end
        err_o = (32'(sel_i) >= 32'(NUM_IN));
    end

endmodule

// File: rtl/sel_pipe_mux.sv
// Selectable mux feeding a two-entry output buffer. Outputs always show the
// main entry; the skid entry absorbs one capture while downstream stalls, so
// in_ready depends only on registered state and never on out_ready.
module sel_pipe_mux
    import sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sel_pipe_mux_if.slave bus,
    output state_t        state_o
);
    localparam int SEL_W = sel_w(NUM_IN);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_t           state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry_d;
    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;

    mux_nway #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data_i (bus.in_data),
        .sel_i     (bus.sel),
        .data_o    (mux_data),
        .err_o     (mux_err)
    );

    // Form the candidate entry and decide whether it is captured this cycle.
    always_comb begin
        new_entry_d = '{err: mux_err, sel: bus.sel, data: mux_data};
        accept      = bus.in_valid && (state_q != FULL) && !bus.flush;
    end

    // Buffer state machine; flush outranks both capture and consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (bus.flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= new_entry_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && bus.out_ready) begin
                        main_q  <= new_entry_d;
                    end else if (accept) begin
                        skid_q  <= new_entry_d;
                        state_q <= FULL;
                    end else if (bus.out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_q.data;
    assign bus.out_sel   = main_q.sel;
    assign bus.out_err   = main_q.err;
    assign state_o       = state_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Bench for sel_pipe_mux: directed scenarios on a 4-source and a 3-source
// build, then a randomized run checked against a FIFO reference model.
module tb_sel_pipe_mux;
    import sel_pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sel_pipe_mux_if #(.WIDTH(5), .NUM_IN(4)) bus4 ();
    sel_pipe_mux_if #(.WIDTH(5), .NUM_IN(3)) bus3 ();
    state_t st4;
    state_t st3;

    sel_pipe_mux #(.WIDTH(5), .NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .state_o(st4)
    );
    sel_pipe_mux #(.WIDTH(5), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .state_o(st3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] src4 = {5'h1F, 5'h0A, 5'h15, 5'h03};
    logic [14:0] src3 = {5'h0A, 5'h15, 5'h03};
    logic [7:0]  exp_q[$];

    // Reference selection: plain shift-and-mask, zero when out of range.
    function automatic logic [4:0] ref_data(input logic [19:0] d, input int s, input int n);
        if (s >= n) return 5'h00;
        return 5'((d >> (s * 5)) & 20'h1F);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus4.in_data = '0; bus4.sel = '0; bus4.in_valid = 0; bus4.out_ready = 0; bus4.flush = 0;
        bus3.in_data = '0; bus3.sel = '0; bus3.in_valid = 0; bus3.out_ready = 0; bus3.flush = 0;
    endtask

    task automatic fill_full4();
        bus4.in_data = src4; bus4.out_ready = 0; bus4.flush = 0;
        bus4.in_valid = 1; bus4.sel = 2'd0;
        step();
        bus4.sel = 2'd1;
        step();
        bus4.in_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 0;
        #1;
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 5'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", bus4.out_data); end
        n_checks++; if (bus4.out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", bus4.out_sel); end
        n_checks++; if (bus4.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", bus4.out_err); end
        n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
        n_checks++; if (st4 !== EMPTY) begin n_fail++; $display("FAIL reset_state: got %0d want EMPTY", st4); end
        n_checks++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset3_out_valid: got %b want 0", bus3.out_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_basic();
        bus4.in_data = src4; bus4.sel = 2'd2; bus4.in_valid = 1; bus4.out_ready = 1;
        step();
        bus4.in_valid = 0;
        n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 5'h0A) begin n_fail++; $display("FAIL basic_data: got %h want 0a", bus4.out_data); end
        n_checks++; if (bus4.out_sel !== 2'd2) begin n_fail++; $display("FAIL basic_sel: got %0d want 2", bus4.out_sel); end
        n_checks++; if (bus4.out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", bus4.out_err); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b want 0", bus4.out_valid); end
        bus4.out_ready = 0;
    endtask

    task automatic test_out_of_range();
        bus3.in_data = src3; bus3.sel = 2'd3; bus3.in_valid = 1; bus3.out_ready = 1;
        step();
        bus3.sel = 2'd1;
        n_checks++; if (bus3.out_data !== 5'h00) begin n_fail++; $display("FAIL oor_data: got %h want 00", bus3.out_data); end
        n_checks++; if (bus3.out_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", bus3.out_err); end
        n_checks++; if (bus3.out_sel !== 2'd3) begin n_fail++; $display("FAIL oor_sel: got %0d want 3", bus3.out_sel); end
        step();
        bus3.in_valid = 0;
        n_checks++; if (bus3.out_data !== 5'h15 || bus3.out_err !== 1'b0) begin
            n_fail++; $display("FAIL in_range3: got data %h err %b want 15 0", bus3.out_data, bus3.out_err);
        end
        step();
        bus3.out_ready = 0;
    endtask

    task automatic test_full_drain();
        fill_full4();
        n_checks++; if (st4 !== FULL) begin n_fail++; $display("FAIL full_state: got %0d want FULL", st4); end
        n_checks++; if (bus4.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus4.in_ready); end
        n_checks++; if (bus4.out_data !== 5'h03) begin n_fail++; $display("FAIL full_head: got %h want 03", bus4.out_data); end
        bus4.out_ready = 1;
        step();
        n_checks++; if (bus4.out_data !== 5'h15 || bus4.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL drain_second: got data %h valid %b want 15 1", bus4.out_data, bus4.out_valid);
        end
        n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready: got %b want 1", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", bus4.out_valid); end
        bus4.out_ready = 0;
    endtask

    task automatic test_flush_full();
        fill_full4();
        bus4.in_valid = 1; bus4.sel = 2'd3; bus4.out_ready = 1; bus4.flush = 1;
        step();
        bus4.flush = 0; bus4.in_valid = 0;
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus4.in_ready); end
        n_checks++; if (st4 !== EMPTY) begin n_fail++; $display("FAIL flush_state: got %0d want EMPTY", st4); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", bus4.out_valid); end
        bus4.out_ready = 0;
    endtask

    task automatic test_random();
        int       accepted = 0;
        int       consumed = 0;
        int       cycles   = 0;
        logic     stall    = 0;
        logic [7:0] prev   = '0;
        logic [7:0] cur;
        logic     v, r, acc, cons;
        logic [1:0]  s;
        logic [19:0] d;
        exp_q.delete();
        while ((accepted < 1000 || exp_q.size() != 0) && cycles < 20000) begin
            cur = {bus4.out_err, bus4.out_sel, bus4.out_data};
            n_checks++; if (bus4.out_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid: got %b want %b at cycle %0d", bus4.out_valid, exp_q.size() != 0, cycles);
            end
            n_checks++; if (bus4.in_ready !== (exp_q.size() < 2)) begin
                n_fail++; $display("FAIL rand_in_ready: got %b want %b at cycle %0d", bus4.in_ready, exp_q.size() < 2, cycles);
            end
            if (stall) begin
                n_checks++; if (cur !== prev) begin
                    n_fail++; $display("FAIL rand_stable: got %h want %h at cycle %0d", cur, prev, cycles);
                end
            end
            if (exp_q.size() != 0) begin
                n_checks++; if (cur !== exp_q[0]) begin
                    n_fail++; $display("FAIL rand_order: got %h want %h at cycle %0d", cur, exp_q[0], cycles);
                end
            end
            v = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            d = 20'($urandom);
            bus4.in_valid = v; bus4.out_ready = r; bus4.sel = s; bus4.in_data = d; bus4.flush = 0;
            acc  = v && (exp_q.size() < 2);
            cons = r && (exp_q.size() != 0);
            stall = (exp_q.size() != 0) && !r;
            if (stall) prev = exp_q[0];
            if (cons) begin
                void'(exp_q.pop_front());
                consumed++;
            end
            if (acc) begin
                exp_q.push_back({1'b0, s, ref_data(d, int'(s), 4)});
                accepted++;
            end
            step();
            cycles++;
        end
        bus4.in_valid = 0; bus4.out_ready = 0;
        n_checks++; if (cycles >= 20000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles want < 20000", cycles); end
        n_checks++; if (consumed != 1000) begin n_fail++; $display("FAIL rand_count: got %0d want 1000", consumed); end
    endtask

    task automatic test_async_reset();
        fill_full4();
        n_checks++; if (st4 !== FULL) begin n_fail++; $display("FAIL areset_prefull: got %0d want FULL", st4); end
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", bus4.in_ready); end
        @(negedge clk);
        rst_n = 1;
        bus4.in_data = src4; bus4.sel = 2'd3; bus4.in_valid = 1; bus4.out_ready = 1;
        step();
        bus4.in_valid = 0;
        n_checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 5'h1F || bus4.out_sel !== 2'd3) begin
            n_fail++; $display("FAIL areset_first: got valid %b data %h sel %0d want 1 1f 3",
                               bus4.out_valid, bus4.out_data, bus4.out_sel);
        end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_drained: got %b want 0", bus4.out_valid); end
        bus4.out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_range();
        test_full_drain();
        test_flush_full();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
